// File: rtl/mem_arbiter_wrr.sv
// rtl/mem_arbiter_wrr.sv - weighted round-robin arbiter from per-channel FIFOs onto one single-port RAM
// Optional feature macro: MEM_ARB_PRIORITY_EN (channel 0 becomes strict priority).
module mem_arbiter_wrr #(
    parameter int CHANNELS      = 3,
    parameter int ADDRESS_WIDTH = 25,
    parameter int DATA_WIDTH    = 16,
    parameter int CH_FIFO_DEPTH = 32,
    parameter int QUOTA         = 4,
    parameter int RAM_LATENCY   = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDRESS_WIDTH*CHANNELS-1:0] ch_address,
    input  logic [CHANNELS-1:0]               ch_wr,
    input  logic [DATA_WIDTH*CHANNELS-1:0]    ch_data_in,
    input  logic [CHANNELS-1:0]               ch_valid,
    output logic [CHANNELS-1:0]               ch_full,
    output logic                              ram_req,
    output logic [ADDRESS_WIDTH-1:0]          ram_address,
    output logic                              ram_wr,
    output logic [DATA_WIDTH-1:0]             ram_data,
    input  logic [DATA_WIDTH-1:0]             ram_q,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic [CHANNELS-1:0]               rd_valid
);
    localparam int PW = $clog2(CH_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(CHANNELS);
    localparam int QW = $clog2(QUOTA + 1);
    localparam int EW = 1 + ADDRESS_WIDTH + DATA_WIDTH;

    logic [EW-1:0]       r_mem    [CHANNELS][CH_FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr [CHANNELS];
    logic [PW-1:0]       r_rd_ptr [CHANNELS];
    logic [CW-1:0]       r_count  [CHANNELS];
    logic [IW-1:0]       r_cur;
    logic [IW-1:0]       w_cur_nxt;
    logic [IW-1:0]       w_gnt;
    logic [QW-1:0]       r_left;
    logic [QW-1:0]       w_left_nxt;
    logic [CHANNELS-1:0] w_push;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_nonempty;
    logic                w_pop_any;
    logic [EW-1:0]       w_head;
    logic [CHANNELS-1:0] r_issue_tag;
    logic [CHANNELS-1:0] r_tag [RAM_LATENCY];

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            ch_full[k]    = (r_count[k] == CW'(CH_FIFO_DEPTH));
            w_nonempty[k] = (r_count[k] != '0);
            w_push[k]     = ch_valid[k] & ~ch_full[k];
        end
    end

    // Search runs farthest-first so the nearest non-empty channel after cur wins; cur itself is last.
    always_comb begin
        w_cur_nxt  = r_cur;
        w_left_nxt = r_left;
        w_gnt      = r_cur;
        w_pop_any  = 1'b0;
`ifdef MEM_ARB_PRIORITY_EN
        if (w_nonempty[0]) begin
            w_gnt     = '0;
            w_pop_any = 1'b1;
        end else
`endif
        if (w_nonempty[r_cur] && (r_left != '0)) begin
            w_pop_any  = 1'b1;
            w_left_nxt = r_left - 1'b1;
        end else begin
            for (int i = CHANNELS; i >= 1; i--) begin
                if (w_nonempty[(int'(r_cur) + i) % CHANNELS]) begin
                    w_gnt      = IW'((int'(r_cur) + i) % CHANNELS);
                    w_cur_nxt  = IW'((int'(r_cur) + i) % CHANNELS);
                    w_left_nxt = QW'(QUOTA - 1);
                    w_pop_any  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pop  = w_pop_any ? (CHANNELS'(1) << w_gnt) : '0;
        w_head = r_mem[w_gnt][r_rd_ptr[w_gnt]];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wr_ptr[k]] <= {ch_wr[k],
                                          ch_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                                          ch_data_in[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (reset) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_count[k]  <= '0;
            end else begin
                if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + 1'b1;
                if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + 1'b1;
                if (w_push[k] && !w_pop[k])      r_count[k] <= r_count[k] + 1'b1;
                else if (!w_push[k] && w_pop[k]) r_count[k] <= r_count[k] - 1'b1;
            end
        end
    end

    // The command register is the first latency stage, so the tag trails it by one more register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur       <= IW'(CHANNELS - 1);
            r_left      <= '0;
            ram_req     <= 1'b0;
            ram_wr      <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            r_issue_tag <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_cur       <= w_cur_nxt;
            r_left      <= w_left_nxt;
            ram_req     <= w_pop_any;
            ram_wr      <= w_pop_any & w_head[EW-1];
            if (w_pop_any) begin
                ram_address <= w_head[DATA_WIDTH +: ADDRESS_WIDTH];
                ram_data    <= w_head[DATA_WIDTH-1:0];
            end
            r_issue_tag <= (w_pop_any && !w_head[EW-1]) ? w_pop : '0;
            r_tag[0]    <= r_issue_tag;
            for (int i = 1; i < RAM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign rd_valid = r_tag[RAM_LATENCY-1];
    assign rd_data  = ram_q;
endmodule

// File: tb/tb_mem_arbiter_wrr.sv
// tb/tb_mem_arbiter_wrr.sv - self-checking bench for mem_arbiter_wrr against a queue-based reference model
module tb_mem_arbiter_wrr;
    localparam int NCH = 3;
    localparam int AW  = 25;
    localparam int DW  = 16;
    localparam int DEP = 32;
    localparam int QTA = 4;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [AW*NCH-1:0] ch_address = '0;
    logic [NCH-1:0]    ch_wr = '0;
    logic [DW*NCH-1:0] ch_data_in = '0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH-1:0]    ch_full;
    logic              ram_req;
    logic [AW-1:0]     ram_address;
    logic              ram_wr;
    logic [DW-1:0]     ram_data;
    logic [DW-1:0]     ram_q = '0;
    logic [DW-1:0]     rd_data;
    logic [NCH-1:0]    rd_valid;

    mem_arbiter_wrr #(.CHANNELS(NCH), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                      .CH_FIFO_DEPTH(DEP), .QUOTA(QTA), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .ch_address(ch_address), .ch_wr(ch_wr),
        .ch_data_in(ch_data_in), .ch_valid(ch_valid), .ch_full(ch_full),
        .ram_req(ram_req), .ram_address(ram_address), .ram_wr(ram_wr),
        .ram_data(ram_data), .ram_q(ram_q), .rd_data(rd_data), .rd_valid(rd_valid));

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t           mq [NCH][$];
    int             m_cur;
    int             m_left;
    logic           m_req, m_wr;
    logic [AW-1:0]  m_addr, m_rd_addr;
    logic [DW-1:0]  m_data;
    logic [NCH-1:0] m_rdv, m_full;
    logic [AW-1:0]  m_addr_hist [$];
    logic [NCH-1:0] m_tag_hist [$];
    logic [AW-1:0]  dut_addr_hist [$];

    int n_checks = 0;
    int n_pass = 0;
    bit rec_order = 0;
    bit rec_rd = 0;
    int order_q [$];
    logic [DW-1:0]  rd_q [$];
    logic [NCH-1:0] rdv_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) mq[k].delete();
        m_cur = NCH - 1; m_left = 0;
        m_req = 0; m_wr = 0; m_addr = '0; m_data = '0; m_rdv = '0; m_full = '0; m_rd_addr = '0;
        m_addr_hist.delete(); m_tag_hist.delete();
        for (int i = 0; i < LAT; i++) begin
            m_addr_hist.push_back('0);
            m_tag_hist.push_back('0);
        end
    endtask

    // Reference rules: strict-priority ch0 (if enabled), else continue turn, else nearest non-empty after cur.
    task automatic model_edge();
        int g;
        ent_t e;
        logic [NCH-1:0] tag;
        logic [NCH-1:0] fullv;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NCH; k++) fullv[k] = (mq[k].size() == DEP);
        g = -1;
`ifdef MEM_ARB_PRIORITY_EN
        if (mq[0].size() > 0) g = 0;
`endif
        if (g < 0 && m_left > 0 && mq[m_cur].size() > 0) begin
            g = m_cur;
            m_left--;
        end else if (g < 0) begin
            for (int i = 1; i <= NCH; i++) begin
                if (mq[(m_cur + i) % NCH].size() > 0) begin
                    g = (m_cur + i) % NCH;
                    m_cur = g;
                    m_left = QTA - 1;
                    break;
                end
            end
        end
        tag = '0;
        if (g >= 0) begin
            e = mq[g].pop_front();
            m_req = 1; m_wr = e.wr; m_addr = e.addr; m_data = e.data;
            if (!e.wr) tag[g] = 1'b1;
        end else begin
            m_req = 0; m_wr = 0;
        end
        m_addr_hist.push_back(m_addr);
        m_tag_hist.push_back(tag);
        m_rd_addr = m_addr_hist.pop_front();
        m_rdv = m_tag_hist.pop_front();
        for (int k = 0; k < NCH; k++) begin
            if (ch_valid[k] && !fullv[k]) begin
                e.wr = ch_wr[k];
                e.addr = ch_address[k*AW +: AW];
                e.data = ch_data_in[k*DW +: DW];
                mq[k].push_back(e);
            end
            m_full[k] = (mq[k].size() == DEP);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        dut_addr_hist.push_back(ram_address);
        ram_q = dut_addr_hist.pop_front() ^ 16'hA5A5;
        #1;
        chk("ram_req", ram_req, m_req);
        chk("ram_wr", ram_wr, m_wr);
        chk("ram_address", ram_address, m_addr);
        chk("ram_data", ram_data, m_data);
        chk("rd_valid", rd_valid, m_rdv);
        if (m_rdv != '0) chk("rd_data", rd_data, m_rd_addr[DW-1:0] ^ 16'hA5A5);
        chk("ch_full", ch_full, m_full);
        if (rec_order && ram_req) order_q.push_back(int'(ram_address[9:8]));
        if (rec_rd && rd_valid != '0) begin
            rd_q.push_back(rd_data);
            rdv_q.push_back(rd_valid);
        end
    endtask

    task automatic set_push(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_valid[k] = 1'b1;
        ch_wr[k] = wr;
        ch_address[k*AW +: AW] = a;
        ch_data_in[k*DW +: DW] = d;
    endtask

    task automatic clear_push();
        ch_valid = '0;
    endtask

    task automatic do_reset();
        clear_push();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_order [18];
        int seen_full2;
        logic [DW-1:0] p2;
        for (int i = 0; i < LAT; i++) dut_addr_hist.push_back('0);
        model_reset();

        // Reset state and single write to ch1
        do_reset();
        chk("reset_req", ram_req, 1'b0);
        chk("reset_full", ch_full, 3'b000);
        chk("reset_rdv", rd_valid, 3'b000);
        set_push(1, 1'b1, 25'h10, 16'hBEEF);
        tick();
        chk("wr1_not_yet", ram_req, 1'b0);
        clear_push();
        tick();
        chk("wr1_req", ram_req, 1'b1);
        chk("wr1_wr", ram_wr, 1'b1);
        chk("wr1_addr", ram_address, 25'h10);
        chk("wr1_data", ram_data, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr1_no_rdv", rd_valid, 3'b000);
        end

        // Three channels with six reads each
        do_reset();
`ifdef MEM_ARB_PRIORITY_EN
        exp_order = '{0,0,0,0,0,0,1,1,1,1,2,2,2,2,1,1,2,2};
`else
        exp_order = '{0,0,0,0,1,1,1,1,2,2,2,2,0,0,1,1,2,2};
`endif
        rec_order = 1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NCH; k++) set_push(k, 1'b0, AW'(k * 'h100 + i), '0);
            tick();
        end
        clear_push();
        for (int i = 0; i < 20; i++) tick();
        rec_order = 0;
        chk("order_len", order_q.size(), 18);
        for (int i = 0; i < 18 && i < order_q.size(); i++) chk("order", order_q[i], exp_order[i]);

        // Ch1 read stream returned through the behavioural RAM
        do_reset();
        rec_rd = 1;
        for (int i = 0; i < 8; i++) begin
            set_push(1, 1'b0, AW'(i), '0);
            tick();
        end
        clear_push();
        for (int i = 0; i < 12; i++) tick();
        rec_rd = 0;
        chk("rd_len", rd_q.size(), 8);
        for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
            chk("rd_seq", rd_q[i], 16'hA5A5 ^ DW'(i));
            chk("rd_tag", rdv_q[i], 3'b010);
        end

        // Saturate every FIFO; ch2 data numbers each attempted push so drops show in the drain order
        do_reset();
        seen_full2 = 0;
        p2 = '0;
        for (int i = 0; i < 70; i++) begin
            set_push(0, 1'b1, 25'h1000 + AW'(i), DW'(i));
            set_push(1, 1'b0, 25'h2000 + AW'(i), DW'(i));
            set_push(2, 1'b1, 25'h3000 + AW'(i), p2);
            p2++;
            tick();
            if (ch_full[2]) seen_full2 = 1;
        end
        chk("ch2_full_seen", seen_full2, 1);
        clear_push();
        for (int i = 0; i < 110; i++) tick();
        chk("drained_full", ch_full, 3'b000);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            clear_push();
            reset = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 99) < 45)
                    set_push(k, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            end
            tick();
        end
        reset = 1'b0;

        // Reset with reads in flight and FIFOs non-empty
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NCH; k++) set_push(k, 1'b0, AW'(k * 16 + i), '0);
            tick();
        end
        clear_push();
        tick();
        chk("pre_reset_req", ram_req, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            tick();
            chk("post_reset_rdv", rd_valid, 3'b000);
            chk("post_reset_req", ram_req, 1'b0);
            chk("post_reset_full", ch_full, 3'b000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_wrr.md
# mem_arbiter_wrr

Parametrised multi-channel memory arbiter; the successor to the fixed three-peripheral arbiter. Each channel has its own request FIFO. A weighted round-robin granter with a per-turn quota issues one command per cycle to an external single-port RAM. Read data returns with a one-hot channel tag aligned to a configurable RAM read latency. It sits between the LED matrix datapath clients (frame writer, scan reader, host port) and the frame-buffer RAM.

## Interface
- CHANNELS, 3, number of requesting channels (≥2)
- ADDRESS_WIDTH, 25, RAM address width
- DATA_WIDTH, 16, RAM data width
- CH_FIFO_DEPTH, 32, entries per channel FIFO; power of two, ≥2
- QUOTA, 4, max consecutive grants to one channel per turn (≥1)
- RAM_LATENCY, 2, cycles from command on ram_* to valid ram_q (≥1)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ch_address  in  ADDRESS_WIDTH*CHANNELS  packed addresses, channel k at [k*AW +: AW]
- ch_wr  in  CHANNELS  1 = write, 0 = read
- ch_data_in  in  DATA_WIDTH*CHANNELS  packed write data
- ch_valid  in  CHANNELS  push request
- ch_full  out  CHANNELS  FIFO full; push ignored while high
- ram_req  out  1  command valid this cycle
- ram_address  out  ADDRESS_WIDTH  registered command address
- ram_wr  out  1  registered write enable; only high with ram_req
- ram_data  out  DATA_WIDTH  registered write data
- ram_q  in  DATA_WIDTH  RAM read data
- rd_data  out  DATA_WIDTH  equals ram_q
- rd_valid  out  CHANNELS  one-hot, marks rd_data for the channel that issued the read

## Operation
- **Channel FIFO:**
  - Push when ch_valid[k] & !ch_full[k]; a push while full is dropped silently.
  - Count is $clog2(DEPTH)+1 bits; ch_full[k] = (count == CH_FIFO_DEPTH), so all entries are usable.
  - Pointers wrap naturally at DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - ch_full is evaluated on the registered count, so a pop does not unblock a same-cycle push.
- **Granter state:**
  - cur (current channel index) and left (remaining quota, 0..QUOTA).
  - Each cycle: if FIFO[cur] is non-empty and left>0, pop it and decrement left.
  - Otherwise, search cur+1, cur+2, … (mod CHANNELS) for the first non-empty FIFO, set cur to it, pop it, and set left=QUOTA-1. There is no bubble on a switch.
  - If all FIFOs are empty: no pop, ram_req=0, ram_wr=0; cur and left hold.
- **Issue stage:**
  - A popped entry registers onto ram_address/ram_wr/ram_data with ram_req=1.
  - For a read, the one-hot channel tag enters a RAM_LATENCY-deep shift register; for a write, zero enters.
  - With no pop, ram_address/ram_data hold their last values.
- **Return:** rd_valid = tag shift-register output, concurrent with ram_q; rd_data = ram_q.
- **Reset values:**
  - ch_full=0, ram_req=0, ram_wr=0, ram_address=0, ram_data=0, rd_valid=0.
  - FIFOs empty, cur=CHANNELS-1, left=0. The first grant therefore goes to the lowest non-empty channel.
- **Reset mid-operation:** FIFO contents are discarded and the tag pipeline is cleared. Reads in flight never assert rd_valid.

## Timing
- Push at edge n makes the entry poppable at edge n+1. Its command appears on ram_* after edge n+1 at the earliest.
- Read command on ram_* in cycle c gives rd_valid/rd_data in cycle c+RAM_LATENCY.
- Throughput: one command per cycle sustained whenever any FIFO is non-empty.
- Fairness: no channel waits more than (CHANNELS-1)*QUOTA grants once its FIFO is non-empty.
- Read data is returned in issue order; there is no reordering.

## Configuration
- MEM_ARB_PRIORITY_EN defined: channel 0 is strict priority.
  - Whenever FIFO[0] is non-empty, it is popped regardless of cur/left.
  - cur and left of the preempted channel are frozen. Rotation resumes there with its remaining quota once FIFO[0] empties.
- Undefined: pure weighted round-robin as in Operation; channel 0 has no precedence.

## Test plan
- Reset, then push 1 write to ch1 (addr 0x10, data 0xBEEF): ram_req=1, ram_wr=1, ram_address=0x10, ram_data=0xBEEF exactly 1 cycle later; rd_valid stays 0.
- Ch0, ch1, ch2 each hold 6 reads, QUOTA=4: issue order is ch0×4, ch1×4, ch2×4, ch0×2, ch1×2, ch2×2 with no idle cycles. Each rd_valid is one-hot to the issuer, RAM_LATENCY=2 cycles after its command.
- Push 32 entries to ch2 with the granter blocked by ch0 traffic under MEM_ARB_PRIORITY_EN: ch_full[2]=1 after the 32nd push. A 33rd push is dropped, and the 32 drained entries match push order.
- Ch1 streams reads of 0..7 with a behavioural RAM returning addr^0xA5A5: rd_data sequence 0xA5A5, 0xA5A4, … in order, with rd_valid=3'b010 on each.
- Assert reset for 1 cycle with 3 reads outstanding and FIFOs non-empty: rd_valid=0 for RAM_LATENCY+5 cycles after reset, ram_req=0, ch_full=0.
- MEM_ARB_PRIORITY_EN: ch1 mid-turn (left=2) when ch0 pushes 3 entries: ch0×3 is issued, then ch1×2, then rotation continues to ch2.
